// File: rtl/race_lap_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : race_lap_controller
//  Description : Race timing and lap sequencing for the game FSM. Tracks race
//                time, current lap time, best lap, lap count and checkpoint
//                ordering; raises is_game_end once the final lap completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module race_lap_controller #(
    parameter int TICK_DIV = 1000000,
    parameter int NUM_CP   = 4,
    parameter int NUM_LAPS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        game_state,
    input  logic [NUM_CP-1:0] cp_hit,
    output logic [2:0]        lap,
    output logic [2:0]        next_cp,
    output logic [19:0]       race_time,
    output logic [19:0]       lap_time,
    output logic [19:0]       best_lap,
    output logic              wrong_way,
    output logic              is_game_end
);

    localparam int          DIV_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [2:0]  GS_IDLE      = 3'd0;
    localparam logic [2:0]  GS_COUNTDOWN = 3'd3;
    localparam logic [2:0]  GS_RACING    = 3'd4;
    localparam logic [2:0]  GS_PAUSE     = 3'd5;
    localparam logic [19:0] TIME_MAX     = 20'h95999;
    localparam logic [2:0]  LAST_CP      = 3'(NUM_CP - 1);
    localparam logic [2:0]  LAP_TARGET   = 3'(NUM_LAPS);

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_ARMED = 3'd1,
        R_RUN   = 3'd2,
        R_HOLD  = 3'd3,
        R_DONE  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [NUM_CP-1:0]  expect_mask;
    logic [NUM_CP-1:0]  last_mask;
    logic [2:0]         prev_cp;
    logic               hit_expected;
    logic               cp_advance;
    logic               lap_done;
    logic               stray_hit;
    logic               final_lap;

    // M:SS.cc BCD increment with per-digit carry, saturating at 9:59.99
    function automatic logic [19:0] bcd_inc(input logic [19:0] v);
        logic [3:0] m, st, so, ct, co;
        {m, st, so, ct, co} = v;
        if (v == TIME_MAX) begin
            return v;
        end
        if (co != 4'd9) begin
            co = co + 4'd1;
        end else begin
            co = 4'd0;
            if (ct != 4'd9) begin
                ct = ct + 4'd1;
            end else begin
                ct = 4'd0;
                if (so != 4'd9) begin
                    so = so + 4'd1;
                end else begin
                    so = 4'd0;
                    if (st != 4'd5) begin
                        st = st + 4'd1;
                    end else begin
                        st = 4'd0;
                        m  = m + 4'd1;
                    end
                end
            end
        end
        return {m, st, so, ct, co};
    endfunction

    // Checkpoint decode: expected hit, last-passed re-hit, and out-of-order hits
    always_comb begin
        prev_cp      = (next_cp == 3'd0) ? LAST_CP : next_cp - 3'd1;
        expect_mask  = NUM_CP'(1) << next_cp;
        last_mask    = NUM_CP'(1) << prev_cp;
        hit_expected = |(cp_hit & expect_mask);
        cp_advance   = hit_expected && (next_cp != 3'd0);
        lap_done     = hit_expected && (next_cp == 3'd0);
        stray_hit    = !hit_expected && (|(cp_hit & ~last_mask));
        final_lap    = lap_done && ((lap + 3'd1) == LAP_TARGET);
        tick         = (div_cnt == DIV_W'(TICK_DIV - 1));
    end

    // Race sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= R_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision from the current game state; end-of-race flag
    always_comb begin
        state_next  = state;
        is_game_end = 1'b0;
        case (state)
            R_IDLE: begin
                if (game_state == GS_COUNTDOWN) state_next = R_ARMED;
            end
            R_ARMED: begin
                if (game_state == GS_RACING)    state_next = R_RUN;
                else if (game_state == GS_IDLE) state_next = R_IDLE;
            end
            R_RUN: begin
                // Leaving to idle wins over finishing; finishing wins over pause
                if (game_state == GS_IDLE)       state_next = R_IDLE;
                else if (final_lap)              state_next = R_DONE;
                else if (game_state == GS_PAUSE) state_next = R_HOLD;
            end
            R_HOLD: begin
                if (game_state == GS_RACING)         state_next = R_RUN;
                else if (game_state == GS_COUNTDOWN) state_next = R_ARMED;
                else if (game_state == GS_IDLE)      state_next = R_IDLE;
            end
            R_DONE: begin
                is_game_end = 1'b1;
                if (game_state == GS_IDLE) state_next = R_IDLE;
            end
            default: state_next = R_IDLE;
        endcase
    end

    // Timing and checkpoint datapath; frozen in R_HOLD and R_DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            lap       <= 3'd0;
            next_cp   <= 3'd1;
            race_time <= 20'h0;
            lap_time  <= 20'h0;
            best_lap  <= TIME_MAX;
            wrong_way <= 1'b0;
            div_cnt   <= '0;
        end else begin
            wrong_way <= 1'b0;
            case (state)
                R_IDLE, R_ARMED: begin
                    lap       <= 3'd0;
                    next_cp   <= 3'd1;
                    race_time <= 20'h0;
                    lap_time  <= 20'h0;
                    div_cnt   <= '0;
                    // A fresh race forgets the best lap; idle keeps it on show
                    if (state == R_ARMED) best_lap <= TIME_MAX;
                end
                R_RUN: begin
                    div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                    if (tick) race_time <= bcd_inc(race_time);
                    if (lap_done) begin
                        // New lap starts at zero, so a coincident tick is dropped
                        lap      <= lap + 3'd1;
                        next_cp  <= 3'd1;
                        lap_time <= 20'h0;
                        if (lap_time < best_lap) best_lap <= lap_time;
                    end else begin
                        if (tick) lap_time <= bcd_inc(lap_time);
                        if (cp_advance) begin
                            next_cp <= (next_cp == LAST_CP) ? 3'd0 : next_cp + 3'd1;
                        end else if (stray_hit) begin
                            wrong_way <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_race_lap_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_race_lap_controller
//  Description : Scoreboard bench for race_lap_controller. Instance A runs a
//                short two-lap race; instance B (one tick per clock) runs to
//                the 9:59.99 saturation point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_race_lap_controller;

    localparam logic [2:0] GS_IDLE = 3'd0, GS_CD = 3'd3, GS_RACE = 3'd4, GS_PAUSE = 3'd5;
    localparam logic [6:0] M_LAP = 7'h01, M_NCP = 7'h02, M_RT = 7'h04, M_LT = 7'h08,
                           M_BL = 7'h10, M_WW = 7'h20, M_GE = 7'h40, M_ALL = 7'h7f;
    localparam logic [19:0] NONE = 20'h95999;

    typedef struct {
        string      name;
        bit         inst;
        bit [6:0]   mask;
        logic [2:0] lap;
        logic [2:0] ncp;
        logic [19:0] rt;
        logic [19:0] lt;
        logic [19:0] bl;
        logic       ww;
        logic       ge;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [2:0]  gs_a, gs_b;
    logic [3:0]  cp_a, cp_b;
    logic [2:0]  lap_a, lap_b, ncp_a, ncp_b;
    logic [19:0] rt_a, rt_b, lt_a, lt_b, bl_a, bl_b;
    logic        ww_a, ww_b, ge_a, ge_b;

    race_lap_controller #(.TICK_DIV(4), .NUM_CP(4), .NUM_LAPS(2)) dut_a (
        .clk(clk), .rst(rst_a), .game_state(gs_a), .cp_hit(cp_a),
        .lap(lap_a), .next_cp(ncp_a), .race_time(rt_a), .lap_time(lt_a),
        .best_lap(bl_a), .wrong_way(ww_a), .is_game_end(ge_a)
    );

    race_lap_controller #(.TICK_DIV(1), .NUM_CP(4), .NUM_LAPS(2)) dut_b (
        .clk(clk), .rst(rst_b), .game_state(gs_b), .cp_hit(cp_b),
        .lap(lap_b), .next_cp(ncp_b), .race_time(rt_b), .lap_time(lt_b),
        .best_lap(bl_b), .wrong_way(ww_b), .is_game_end(ge_b)
    );

    // Queue an expectation about the outputs visible after the latest posedge
    function automatic void push(input string nm, input bit inst, input bit [6:0] m,
                                 input logic [2:0] lp, input logic [2:0] ncp,
                                 input logic [19:0] rt, input logic [19:0] lt,
                                 input logic [19:0] bl, input logic ww, input logic ge);
        exp_t e;
        e.name = nm; e.inst = inst; e.mask = m; e.lap = lp; e.ncp = ncp;
        e.rt = rt; e.lt = lt; e.bl = bl; e.ww = ww; e.ge = ge;
        sb.push_back(e);
    endfunction

    task automatic chk(input string nm, input string f, input logic [19:0] act, input logic [19:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h, expected %h", nm, f, act, exp);
        end
    endtask

    // Monitor: on each falling edge drain the scoreboard against the outputs
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 1'b0) begin
                if (e.mask[0]) chk(e.name, "lap",       20'(lap_a), 20'(e.lap));
                if (e.mask[1]) chk(e.name, "next_cp",   20'(ncp_a), 20'(e.ncp));
                if (e.mask[2]) chk(e.name, "race_time", rt_a, e.rt);
                if (e.mask[3]) chk(e.name, "lap_time",  lt_a, e.lt);
                if (e.mask[4]) chk(e.name, "best_lap",  bl_a, e.bl);
                if (e.mask[5]) chk(e.name, "wrong_way", 20'(ww_a), 20'(e.ww));
                if (e.mask[6]) chk(e.name, "game_end",  20'(ge_a), 20'(e.ge));
            end else begin
                if (e.mask[0]) chk(e.name, "lap",       20'(lap_b), 20'(e.lap));
                if (e.mask[1]) chk(e.name, "next_cp",   20'(ncp_b), 20'(e.ncp));
                if (e.mask[2]) chk(e.name, "race_time", rt_b, e.rt);
                if (e.mask[3]) chk(e.name, "lap_time",  lt_b, e.lt);
                if (e.mask[4]) chk(e.name, "best_lap",  bl_b, e.bl);
                if (e.mask[5]) chk(e.name, "wrong_way", 20'(ww_b), 20'(e.ww));
                if (e.mask[6]) chk(e.name, "game_end",  20'(ge_b), 20'(e.ge));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [3:0] h);
        cp_a = h;
        cyc(1);
        cp_a = 4'b0;
    endtask

    // Instance A: two-lap race, TICK_DIV=4 (one centisecond per 4 run cycles)
    task automatic seq_a();
        rst_a = 1'b1; gs_a = GS_IDLE; cp_a = 4'b0;
        cyc(2);
        rst_a = 1'b0;
        push("reset", 0, M_ALL, 3'd0, 3'd1, 20'h0, 20'h0, NONE, 1'b0, 1'b0);
        gs_a = GS_CD;   cyc(1);
        gs_a = GS_RACE; cyc(1);
        cyc(400);
        push("one_second", 0, M_LAP | M_NCP | M_RT | M_LT, 3'd0, 3'd1, 20'h00100, 20'h00100, NONE, 1'b0, 1'b0);
        // Lap 1: each pulse plus 3 gap cycles is exactly one tick
        pulse_a(4'b0010); push("cp1", 0, M_NCP | M_WW, 3'd0, 3'd2, 20'h0, 20'h0, NONE, 1'b0, 1'b0); cyc(3);
        pulse_a(4'b0100); push("cp2", 0, M_NCP | M_WW, 3'd0, 3'd3, 20'h0, 20'h0, NONE, 1'b0, 1'b0); cyc(3);
        pulse_a(4'b1000); push("cp3", 0, M_NCP | M_WW, 3'd0, 3'd0, 20'h0, 20'h0, NONE, 1'b0, 1'b0); cyc(3);
        push("pre_lap1", 0, M_RT | M_LT, 3'd0, 3'd0, 20'h00103, 20'h00103, NONE, 1'b0, 1'b0);
        pulse_a(4'b0001);
        push("lap1", 0, M_LAP | M_NCP | M_RT | M_LT | M_BL | M_GE, 3'd1, 3'd1, 20'h00103, 20'h0, 20'h00103, 1'b0, 1'b0);
        cyc(3);
        // Lap 2 ordering checks
        pulse_a(4'b0010); push("l2_cp1", 0, M_NCP, 3'd0, 3'd2, 20'h0, 20'h0, NONE, 1'b0, 1'b0); cyc(3);
        pulse_a(4'b0001); push("ww_on", 0, M_NCP | M_WW, 3'd0, 3'd2, 20'h0, 20'h0, NONE, 1'b1, 1'b0);
        cyc(1);           push("ww_off", 0, M_NCP | M_WW, 3'd0, 3'd2, 20'h0, 20'h0, NONE, 1'b0, 1'b0); cyc(2);
        pulse_a(4'b0010); push("rehit_last", 0, M_NCP | M_WW, 3'd0, 3'd2, 20'h0, 20'h0, NONE, 1'b0, 1'b0); cyc(3);
        pulse_a(4'b0101); push("multi_hit", 0, M_NCP | M_WW, 3'd0, 3'd3, 20'h0, 20'h0, NONE, 1'b0, 1'b0); cyc(3);
        push("pre_pause", 0, M_RT | M_LT, 3'd0, 3'd0, 20'h00108, 20'h00005, NONE, 1'b0, 1'b0);
        // Pause with the divider at 2 of 0..3
        cyc(1);
        gs_a = GS_PAUSE; cyc(1);
        cyc(500); pulse_a(4'b1000); cyc(499);
        push("paused", 0, M_RT | M_LT | M_NCP | M_WW, 3'd0, 3'd3, 20'h00108, 20'h00005, NONE, 1'b0, 1'b0);
        gs_a = GS_RACE; cyc(1);
        cyc(1); push("resume_wait", 0, M_RT, 3'd0, 3'd0, 20'h00108, 20'h0, NONE, 1'b0, 1'b0);
        cyc(1); push("resume_tick", 0, M_RT | M_LT, 3'd0, 3'd0, 20'h00109, 20'h00006, NONE, 1'b0, 1'b0);
        // Finish lap 2, faster than lap 1
        pulse_a(4'b1000); cyc(3);
        pulse_a(4'b0001);
        push("lap2_end", 0, M_LAP | M_NCP | M_RT | M_LT | M_BL | M_GE, 3'd2, 3'd1, 20'h00110, 20'h0, 20'h00007, 1'b0, 1'b1);
        cyc(10); pulse_a(4'b0010); cyc(5); pulse_a(4'b0001); cyc(10);
        push("done_frozen", 0, M_ALL, 3'd2, 3'd1, 20'h00110, 20'h0, 20'h00007, 1'b0, 1'b1);
        gs_a = GS_IDLE; cyc(2);
        push("idle_keep_best", 0, M_ALL, 3'd0, 3'd1, 20'h0, 20'h0, 20'h00007, 1'b0, 1'b0);
        gs_a = GS_CD; cyc(2);
        push("armed_clear", 0, M_BL | M_LAP | M_RT | M_GE, 3'd0, 3'd0, 20'h0, 20'h0, NONE, 1'b0, 1'b0);
        gs_a = GS_RACE; cyc(20); pulse_a(4'b0010); cyc(1);
        rst_a = 1'b1; cyc(1);
        push("mid_race_rst", 0, M_ALL, 3'd0, 3'd1, 20'h0, 20'h0, NONE, 1'b0, 1'b0);
        rst_a = 1'b0; cyc(3);
        push("rst_stays_idle", 0, M_ALL, 3'd0, 3'd1, 20'h0, 20'h0, NONE, 1'b0, 1'b0);
    endtask

    // Instance B: one tick per run cycle, drive race time to saturation
    task automatic seq_b();
        rst_b = 1'b1; gs_b = GS_IDLE; cp_b = 4'b0;
        cyc(2);
        rst_b = 1'b0;
        gs_b = GS_CD;   cyc(1);
        gs_b = GS_RACE; cyc(1);
        cyc(6000);  push("b_one_minute", 1, M_RT | M_LT, 3'd0, 3'd0, 20'h10000, 20'h10000, NONE, 1'b0, 1'b0);
        cyc(53998); push("b_9_59_98", 1, M_RT | M_LT | M_LAP, 3'd0, 3'd0, 20'h95998, 20'h95998, NONE, 1'b0, 1'b0);
        cyc(3);     push("b_saturate", 1, M_RT | M_LT | M_GE, 3'd0, 3'd0, 20'h95999, 20'h95999, NONE, 1'b0, 1'b0);
    endtask

    initial begin
        fork
            seq_a();
            seq_b();
        join
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        n_bad++;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
